// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback/register-file slice.
// Holds the writeback source select encoding, fixed register indices and the
// default datapath widths.
// Consumers: wb_grf_stage_if, grf_core, wb_grf_stage (via import cpu_pkg::*).
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        WSEL_ALU  = 3'd0,
        WSEL_DM   = 3'd1,
        WSEL_LINK = 3'd2,
        WSEL_EXT  = 3'd3,
        WSEL_MDU  = 3'd4
    } wsel_e;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/wb_grf_stage_if.sv
// W-stage bus: bundle from the M/W pipeline register, D-stage read ports and
// the W-stage result exported to hazard/forwarding logic.
// Modports:
//   master - pipeline side: drives the W bundle and read indices, sees results
//   slave  - wb_grf_stage: consumes the bundle, returns read data and result
interface wb_grf_stage_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [2:0]        w_sel;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_dmout;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_mdu;
    logic [DATA_W-1:0] w_pc;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_we;

    modport master (
        output w_we, w_addr, w_sel, w_alu, w_dmout, w_ext, w_mdu, w_pc,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, wb_data, wb_addr, wb_we
    );

    modport slave (
        input  w_we, w_addr, w_sel, w_alu, w_dmout, w_ext, w_mdu, w_pc,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, wb_data, wb_addr, wb_we
    );
endinterface

// File: rtl/grf_core.sv
// General register file core: 2**ADDR_W x DATA_W storage, one write port and
// two combinational read ports with same-cycle write-to-read bypass.
// Ports:
//   clk, reset          - clock, synchronous active-high reset (clears storage)
//   i_we/i_waddr/i_wdata - qualified write port (i_we already excludes $0)
//   i_raddr_a/b         - read indices
//   o_rdata_a/b         - read data ($0 always reads 0)
module grf_core
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];

    // Entry 0 is never written, so it stays at its reset value; reads of $0
    // are forced to zero below regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != ADDR_W'(REG_ZERO))) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Write-before-read: the value being written this cycle is visible now.
    assign o_rdata_a = (i_raddr_a == ADDR_W'(REG_ZERO)) ? '0 :
                       (i_we && (i_raddr_a == i_waddr)) ? i_wdata :
                       r_regs[i_raddr_a];

    assign o_rdata_b = (i_raddr_b == ADDR_W'(REG_ZERO)) ? '0 :
                       (i_we && (i_raddr_b == i_waddr)) ? i_wdata :
                       r_regs[i_raddr_b];
endmodule

// File: rtl/wb_grf_stage.sv
// Writeback stage of the 5-stage MIPS pipeline.
// Selects the writeback datum from the W-stage bundle, qualifies the write
// enable, commits to the register file (grf_core) and exports the effective
// W-stage result for hazard/forwarding logic.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - wb_grf_stage_if.slave (W bundle in, read data / result out)
// Optional build macro:
//   WB_TRACE_EN - print "@<pc>: $<rd> <= <data>" for every committed write
module wb_grf_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINK_OFFSET = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    wb_grf_stage_if.slave         bus
);
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_legal;
    logic              w_wb_we;
    logic [ADDR_W-1:0] w_wb_addr;

    // Encodings 5..7 are illegal: value forced to 0 and the write dropped.
    always_comb begin
        w_sel_data  = '0;
        w_sel_legal = 1'b1;
        case (bus.w_sel)
            WSEL_ALU:  w_sel_data = bus.w_alu;
            WSEL_DM:   w_sel_data = bus.w_dmout;
            WSEL_LINK: w_sel_data = bus.w_pc + DATA_W'(LINK_OFFSET);
            WSEL_EXT:  w_sel_data = bus.w_ext;
            WSEL_MDU:  w_sel_data = bus.w_mdu;
            default:   w_sel_legal = 1'b0;
        endcase
    end

    assign w_wb_we   = bus.w_we && (bus.w_addr != ADDR_W'(REG_ZERO)) && w_sel_legal;
    assign w_wb_addr = w_wb_we ? bus.w_addr : ADDR_W'(REG_ZERO);

    assign bus.wb_data = w_sel_data;
    assign bus.wb_we   = w_wb_we;
    assign bus.wb_addr = w_wb_addr;

    grf_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_grf_core (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_wb_we),
        .i_waddr   (w_wb_addr),
        .i_wdata   (w_sel_data),
        .i_raddr_a (bus.rs_addr),
        .i_raddr_b (bus.rt_addr),
        .o_rdata_a (bus.rs_data),
        .o_rdata_b (bus.rt_data)
    );

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_wb_we) begin
            $display("@%08h: $%0d <= %08h", bus.w_pc, bus.w_addr, w_sel_data);
        end
    end
`endif
endmodule
